pcie_axil_mmio_bridge: RTL

Converts the shell's 32-bit AXI4-Lite master (PCIE_M_AXI_LITE) into a single-outstanding MMIO request/response bus consumed by the simulator control-register fabric inside custom_logic. It sits directly downstream of the PCIe shell's AXI-Lite port. It serializes reads and writes with round-robin arbitration. A WAIT-state timeout answers SLVERR so the host driver never hangs on a missing response.

---
 rtl/pcie_mmio_pkg.sv | 18 +
 rtl/mmio_wait_timer.sv | 31 +++
 rtl/pcie_axil_mmio_bridge.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pcie_mmio_pkg.sv
// Shared types and constants for the PCIe AXI-Lite to MMIO bridge.
//   state_t        : bridge FSM states
//   RESP_OKAY/SLVERR: AXI response encodings returned on B/R
//   TIMEOUT_RDATA  : read data returned when the MMIO fabric never answers
package pcie_mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mmio_wait_timer.sv
// Response-wait timer for the MMIO bridge.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the count (held while not waiting)
//   enable   : count one cycle of waiting
//   expire   : high in the last allowed wait cycle (count == TIMEOUT_CYCLES-1)
module mmio_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  assign expire = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

  // Stop at the terminal value so a non-power-of-two limit never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pcie_axil_mmio_bridge.sv
// AXI4-Lite slave to single-outstanding MMIO request/response bridge.
//   axi_aclk / axi_areset : clock, synchronous active-high reset
//   s_axil_aw* / w* / b*  : AXI-Lite write channels (AW and W captured independently)
//   s_axil_ar* / r*       : AXI-Lite read channels
//   mmio_req_*            : request to the register fabric, held until mmio_req_ready
//   mmio_rsp_*            : single-cycle response pulse, accepted only while waiting
//   timeout_count         : saturating count of requests answered by the wait timeout
// Reads and writes alternate priority after every issued request.
module pcie_axil_mmio_bridge
  import pcie_mmio_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                axi_aclk,
  input  logic                axi_areset,
  input  logic [ADDR_W-1:0]   s_axil_awaddr,
  input  logic [2:0]          s_axil_awprot,
  input  logic                s_axil_awvalid,
  output logic                s_axil_awready,
  input  logic [DATA_W-1:0]   s_axil_wdata,
  input  logic [DATA_W/8-1:0] s_axil_wstrb,
  input  logic                s_axil_wvalid,
  output logic                s_axil_wready,
  output logic [1:0]          s_axil_bresp,
  output logic                s_axil_bvalid,
  input  logic                s_axil_bready,
  input  logic [ADDR_W-1:0]   s_axil_araddr,
  input  logic [2:0]          s_axil_arprot,
  input  logic                s_axil_arvalid,
  output logic                s_axil_arready,
  output logic [DATA_W-1:0]   s_axil_rdata,
  output logic [1:0]          s_axil_rresp,
  output logic                s_axil_rvalid,
  input  logic                s_axil_rready,
  output logic                mmio_req_valid,
  input  logic                mmio_req_ready,
  output logic                mmio_req_write,
  output logic [ADDR_W-1:0]   mmio_req_addr,
  output logic [DATA_W-1:0]   mmio_req_wdata,
  output logic [DATA_W/8-1:0] mmio_req_wstrb,
  input  logic                mmio_rsp_valid,
  input  logic [DATA_W-1:0]   mmio_rsp_rdata,
  input  logic                mmio_rsp_err,
  output logic [15:0]         timeout_count
);

  state_t state, state_next;

  logic                aw_held, w_held, is_write, prio_rd;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [1:0]          resp_q;

  logic in_idle, rd_open, accept_rd, aw_hs, w_hs, go_write, resp_done;
  logic timer_expire;

  // Protection bits carry no meaning for the register fabric.
  logic unused_prot;
  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  mmio_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (axi_aclk),
    .rst   (axi_areset),
    .clear (state != ST_WAIT),
    .enable(state == ST_WAIT),
    .expire(timer_expire)
  );

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    // Readies are gated by reset so nothing handshakes while reset is held.
    in_idle        = (state == ST_IDLE) && !axi_areset;
    rd_open        = in_idle && !aw_held && !w_held &&
                     (prio_rd || (!s_axil_awvalid && !s_axil_wvalid));
    accept_rd      = rd_open && s_axil_arvalid;
    s_axil_arready = rd_open;
    s_axil_awready = in_idle && !aw_held && !accept_rd;
    s_axil_wready  = in_idle && !w_held && !accept_rd;
    aw_hs          = s_axil_awvalid && s_axil_awready;
    w_hs           = s_axil_wvalid && s_axil_wready;
    go_write       = in_idle && !accept_rd && (aw_held || aw_hs) && (w_held || w_hs);
    resp_done      = (state == ST_RESP) && (is_write ? s_axil_bready : s_axil_rready);
    mmio_req_valid = (state == ST_REQ);
    s_axil_bvalid  = (state == ST_RESP) && is_write;
    s_axil_rvalid  = (state == ST_RESP) && !is_write;

    case (state)
      ST_IDLE: if (accept_rd || go_write) state_next = ST_REQ;
      ST_REQ:  if (mmio_req_ready) state_next = ST_WAIT;
      ST_WAIT: if (mmio_rsp_valid || timer_expire) state_next = ST_RESP;
      ST_RESP: if (resp_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      is_write      <= 1'b0;
      prio_rd       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rdata_q       <= '0;
      resp_q        <= RESP_OKAY;
      timeout_count <= '0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        addr_q  <= s_axil_awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axil_wdata;
        wstrb_q <= s_axil_wstrb;
      end
      // accept_rd excludes both AW and W handshakes, so addr_q/wdata_q have one writer per cycle.
      if (accept_rd) begin
        addr_q   <= s_axil_araddr;
        wdata_q  <= '0;
        wstrb_q  <= '0;
        is_write <= 1'b0;
        prio_rd  <= 1'b0;
      end
      if (go_write) begin
        is_write <= 1'b1;
        prio_rd  <= 1'b1;
      end
      if (state == ST_WAIT) begin
        if (mmio_rsp_valid) begin
          rdata_q <= mmio_rsp_rdata;
          resp_q  <= mmio_rsp_err ? RESP_SLVERR : RESP_OKAY;
        end else if (timer_expire) begin
          rdata_q <= DATA_W'(TIMEOUT_RDATA);
          resp_q  <= RESP_SLVERR;
          if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
        end
      end
      if (resp_done) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  assign mmio_req_write = is_write;
  assign mmio_req_addr  = addr_q;
  assign mmio_req_wdata = wdata_q;
  assign mmio_req_wstrb = wstrb_q;
  assign s_axil_bresp   = resp_q;
  assign s_axil_rresp   = resp_q;
  assign s_axil_rdata   = rdata_q;

endmodule
